// File: rtl/refine_window_ctrl.sv
// Instruction-window sequencer for ILA-to-RTL refinement checking: start/run/done
// windowing, sticky first-failure capture. Define REFINE_SECOND_END_EN to add the second check at END2_CYCLE.

module refine_window_ctrl #(
    parameter int CNT_W      = 4,
    parameter int END_CYCLE  = 1,
    parameter int END2_CYCLE = 3,
    parameter int MAX_CYCLE  = 6,
    parameter int WEN_START  = 3,
    parameter int NUM_MAP    = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_i,
    input  logic                           rearm_i,
    input  logic                           decode_i,
    input  logic [NUM_MAP-1:0]             map_i,
    input  logic [NUM_MAP-1:0]             map_en_i,
    input  logic                           mem_eq_i,
    output logic                           start_o,
    output logic                           started_o,
    output logic [CNT_W-1:0]               cycle_cnt_o,
    output logic                           iend_o,
    output logic                           ended_o,
    output logic                           ended2_o,
    output logic                           mem_compare_o,
    output logic                           mem_wen_gate_o,
    output logic                           fail_o,
    output logic [$clog2(NUM_MAP+1)-1:0]   fail_idx_o,
    output logic [7:0]                     insn_cnt_o
);

    localparam int IDX_W = $clog2(NUM_MAP + 1);

`ifdef REFINE_SECOND_END_EN
    localparam bit SECOND_EN = 1'b1;
`else
    localparam bit SECOND_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] END_V   = CNT_W'(END_CYCLE);
    localparam logic [CNT_W-1:0] END2_V  = CNT_W'(END2_CYCLE);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_CYCLE);
    localparam logic [CNT_W-1:0] WEN_V   = CNT_W'(WEN_START);
    localparam logic [IDX_W-1:0] MEM_IDX = IDX_W'(NUM_MAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_decode_q;
    logic               r_ended;
    logic               r_ended2;
    logic               r_fail;
    logic [IDX_W-1:0]   r_fail_idx;
    logic [7:0]         r_insn_cnt;

    logic               w_issue;
    logic               w_rearm;
    logic               w_iend;
    logic               w_chk2;
    logic               w_final;
    logic               w_mismatch;
    logic               w_fail_set;
    logic [IDX_W-1:0]   w_fail_idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: a default assignment at the top of every always_comb keeps each path
    // assigned, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (issue_i) w_state_nxt = S_START;
            S_START: w_state_nxt = S_RUN;
            S_RUN:   if (w_final) w_state_nxt = S_DONE;
            S_DONE:  if (rearm_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        start_o   = 1'b0;
        started_o = 1'b0;
        case (r_state)
            S_START:      start_o   = 1'b1;
            S_RUN,
            S_DONE:       started_o = 1'b1;
            default:      ;
        endcase
    end

    assign w_issue = (r_state == S_IDLE) & issue_i;
    assign w_rearm = (r_state == S_DONE) & rearm_i;

    // The second check is gated by a compile-time constant; without the feature
    // r_ended2 can never set and ended2_o stays 0.
    assign w_iend  = started_o & (r_cnt == END_V) & ~r_ended;
    assign w_chk2  = SECOND_EN & started_o & (r_cnt == END2_V) & r_ended & ~r_ended2;
    assign w_final = SECOND_EN ? w_chk2 : w_iend;

    assign w_mismatch = (|(map_en_i & ~map_i)) | ~mem_eq_i;
    assign w_fail_set = (w_iend | w_chk2) & r_decode_q & w_mismatch & ~r_fail;

    // Lowest enabled failing map wins; memory is reported only when no map fails.
    always_comb begin
        w_fail_idx = MEM_IDX;
        for (int i = NUM_MAP - 1; i >= 0; i--) begin
            if (map_en_i[i] && !map_i[i]) begin
                w_fail_idx = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window counter and per-window flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_decode_q <= 1'b0;
            r_ended    <= 1'b0;
            r_ended2   <= 1'b0;
        end else begin
            if (w_issue || w_rearm) begin
                r_cnt <= '0;
            end else if ((r_state == S_START || r_state == S_RUN) && r_cnt < MAX_V) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == S_START) begin
                r_decode_q <= decode_i;
            end else if (w_rearm) begin
                r_decode_q <= 1'b0;
            end

            if (w_iend) begin
                r_ended <= 1'b1;
            end else if (w_rearm) begin
                r_ended <= 1'b0;
            end

            if (w_chk2) begin
                r_ended2 <= 1'b1;
            end else if (w_rearm) begin
                r_ended2 <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky failure capture and checked-instruction count (survive re-arm)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
            r_insn_cnt <= '0;
        end else begin
            if (w_fail_set) begin
                r_fail     <= 1'b1;
                r_fail_idx <= w_fail_idx;
            end

            if (r_state == S_RUN && w_final && r_decode_q && r_insn_cnt != 8'hFF) begin
                r_insn_cnt <= r_insn_cnt + 8'd1;
            end
        end
    end

    assign cycle_cnt_o    = r_cnt;
    assign iend_o         = w_iend;
    assign ended_o        = r_ended;
    assign ended2_o       = r_ended2;
    assign mem_compare_o  = w_iend | r_ended;
    assign mem_wen_gate_o = started_o & (r_cnt >= WEN_V);
    assign fail_o         = r_fail;
    assign fail_idx_o     = r_fail_idx;
    assign insn_cnt_o     = r_insn_cnt;

endmodule

// File: tb/tb_refine_window_ctrl.sv
// Scoreboard bench for refine_window_ctrl: window results are queued at issue and
// checked by a monitor when the window completes; timing and boundaries are checked inline.

module tb_refine_window_ctrl;

    localparam int NUM_MAP = 15;
    localparam int END_C   = 1;
`ifdef REFINE_SECOND_END_EN
    localparam int FINAL_CNT = 4;
    localparam int SAT_END   = 5;
    localparam bit SECOND    = 1'b1;
`else
    localparam int FINAL_CNT = 2;
    localparam int SAT_END   = 6;
    localparam bit SECOND    = 1'b0;
`endif
    localparam logic [14:0] ALL1 = 15'h7FFF;

    typedef struct packed {
        logic       fail;
        logic [3:0] idx;
        logic [7:0] insn;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue = 1'b0;
    logic        rearm = 1'b0;
    logic        decode = 1'b0;
    logic [14:0] map = '1;
    logic [14:0] map_en = '1;
    logic        mem_eq = 1'b1;

    logic        start, started, iend, ended, ended2, mem_cmp, wen_gate, fail;
    logic [3:0]  cnt, fail_idx;
    logic [7:0]  insn;

    logic        sat_issue = 1'b0;
    logic        sat_rearm = 1'b0;
    logic        sat_start, sat_started, sat_iend, sat_ended, sat_ended2, sat_mem_cmp, sat_gate, sat_fail;
    logic [3:0]  sat_cnt, sat_fail_idx;
    logic [7:0]  sat_insn;

    logic        done_sig;
    logic        prev_done;

    refine_window_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .issue_i(issue), .rearm_i(rearm), .decode_i(decode),
        .map_i(map), .map_en_i(map_en), .mem_eq_i(mem_eq),
        .start_o(start), .started_o(started), .cycle_cnt_o(cnt), .iend_o(iend),
        .ended_o(ended), .ended2_o(ended2), .mem_compare_o(mem_cmp), .mem_wen_gate_o(wen_gate),
        .fail_o(fail), .fail_idx_o(fail_idx), .insn_cnt_o(insn)
    );

    refine_window_ctrl #(
        .CNT_W(4), .END_CYCLE(SAT_END), .END2_CYCLE(6), .MAX_CYCLE(6), .WEN_START(3), .NUM_MAP(NUM_MAP)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .issue_i(sat_issue), .rearm_i(sat_rearm), .decode_i(decode),
        .map_i(map), .map_en_i(map_en), .mem_eq_i(mem_eq),
        .start_o(sat_start), .started_o(sat_started), .cycle_cnt_o(sat_cnt), .iend_o(sat_iend),
        .ended_o(sat_ended), .ended2_o(sat_ended2), .mem_compare_o(sat_mem_cmp), .mem_wen_gate_o(sat_gate),
        .fail_o(sat_fail), .fail_idx_o(sat_fail_idx), .insn_cnt_o(sat_insn)
    );

    always #5 clk = ~clk;

    assign done_sig = SECOND ? ended2 : ended;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done_sig && k < 20) begin
            cyc();
            k++;
        end
        check("done_reached", done_sig, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, start, 0);
        check({tag, "_started"}, started, 0);
        check({tag, "_cnt"}, cnt, 0);
        check({tag, "_iend"}, iend, 0);
        check({tag, "_ended"}, ended, 0);
        check({tag, "_ended2"}, ended2, 0);
        check({tag, "_mem_cmp"}, mem_cmp, 0);
        check({tag, "_wen_gate"}, wen_gate, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_fail_idx"}, fail_idx, 0);
        check({tag, "_insn"}, insn, 0);
    endtask

    task automatic rearm_window();
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        check("rearm_started", started, 0);
        check("rearm_cnt", cnt, 0);
        check("rearm_ended", ended, 0);
        check("rearm_ended2", ended2, 0);
    endtask

    // One full window with inputs held constant; optionally pokes rearm in START
    // and issue in RUN, both of which must be ignored.
    task automatic run_window(input logic dec, input logic [14:0] m, input logic [14:0] en,
                              input logic meq, input logic exp_fail, input logic [3:0] exp_idx,
                              input logic [7:0] exp_insn, input bit probe);
        exp_t e;
        e.fail = exp_fail;
        e.idx  = exp_idx;
        e.insn = exp_insn;
        e.cnt  = 4'(FINAL_CNT);
        sb.push_back(e);

        decode = dec; map = m; map_en = en; mem_eq = meq;
        issue = 1'b1;
        cyc();
        issue = 1'b0;
        check("start_pulse", start, 1);
        check("start_cnt", cnt, 0);
        check("start_iend", iend, 0);
        if (probe) rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        check("iend_at_end", iend, 1);
        check("mem_cmp_at_iend", mem_cmp, 1);
        check("cnt_at_iend", cnt, END_C);
        if (probe) begin
            issue = 1'b1;
            cyc();
            issue = 1'b0;
            check("issue_in_run_ignored", start, 0);
        end else begin
            cyc();
        end
        check("ended_set", ended, 1);
        check("iend_once", iend, 0);
        wait_done();
        cyc();
        check("wen_gate_done", wen_gate, (FINAL_CNT >= 3));
        rearm_window();
    endtask

    // Scoreboard monitor: a completed window presents its results on the cycle
    // its final-check flag rises.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done <= 1'b0;
        end else begin
            if (done_sig && !prev_done) begin
                check("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("win_fail", fail, e.fail);
                    check("win_fail_idx", fail_idx, e.idx);
                    check("win_insn", insn, e.insn);
                    check("win_cnt", cnt, e.cnt);
                end
            end
            prev_done <= done_sig;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_cnt;

        cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Clean window, then first failure (maps 5 and 9), then a later map-2 failure.
        run_window(1'b1, ALL1, ALL1, 1'b1, 1'b0, 4'd0, 8'd1, 1'b1);
        run_window(1'b1, 15'h7DDF, ALL1, 1'b1, 1'b1, 4'd5, 8'd2, 1'b0);
        run_window(1'b1, 15'h7FFB, ALL1, 1'b1, 1'b1, 4'd5, 8'd3, 1'b0);

        do_reset();
        check("rst_fail_cleared", fail, 0);
        check("rst_insn_cleared", insn, 0);

        // Map 5 disabled but failing, memory failing: memory index reported.
        run_window(1'b1, 15'h7FDF, 15'h7FDF, 1'b0, 1'b1, 4'd15, 8'd1, 1'b0);

        do_reset();
        // decode=0 with a mismatch present: no check, no count; next issue still accepted.
        run_window(1'b0, 15'h7FF7, ALL1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        run_window(1'b1, ALL1, ALL1, 1'b1, 1'b0, 4'd0, 8'd1, 1'b0);

        // Saturating instance: counter tops out at 6, write gate opens from 3.
        decode = 1'b1; map = ALL1; map_en = ALL1; mem_eq = 1'b1;
        sat_issue = 1'b1;
        cyc();
        sat_issue = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_cnt = (i < 6) ? i : 6;
            check("sat_cnt", sat_cnt, exp_cnt);
            check("sat_wen_gate", sat_gate, (i >= 1 && exp_cnt >= 3));
            cyc();
        end
        check("sat_ended", sat_ended, 1);
        check("sat_ended2", sat_ended2, SECOND);
        check("sat_started", sat_started, 1);
        check("sat_start", sat_start, 0);
        check("sat_iend", sat_iend, 0);
        check("sat_mem_cmp", sat_mem_cmp, 1);
        check("sat_insn", sat_insn, 1);
        check("sat_fail", sat_fail, 0);
        check("sat_fail_idx", sat_fail_idx, 0);

        // Asynchronous reset in the middle of a window.
        decode = 1'b1; map = ALL1; map_en = ALL1; mem_eq = 1'b1;
        issue = 1'b1;
        cyc();
        issue = 1'b0;
        k = 0;
        while (cnt != 4'd2 && k < 20) begin
            cyc();
            k++;
        end
        check("mid_cnt_reached", cnt, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        cyc();
        rst_n = 1'b1;
        cyc();

`ifdef REFINE_SECOND_END_EN
        // Map 0 drops after the primary check passed; the second check catches it.
        begin
            exp_t e;
            e.fail = 1'b1; e.idx = 4'd0; e.insn = 8'd1; e.cnt = 4'd4;
            sb.push_back(e);
        end
        issue = 1'b1;
        cyc();
        issue = 1'b0;
        k = 0;
        while (cnt != 4'd3 && k < 20) begin
            cyc();
            k++;
        end
        check("second_cnt_reached", cnt, 3);
        check("second_fail_before", fail, 0);
        map = 15'h7FFE;
        wait_done();
        check("second_ended2", ended2, 1);
        cyc();
        rearm_window();
        map = ALL1;
`endif

        cyc();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
